// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipeline control unit.
//   - RV32I major opcodes recognised by the decoder
//   - immediate-format select encodings
//   - control bundle layout (packed struct, MSB..LSB) and its bit positions
package ctrl_pkg;

  localparam int CTRL_W    = 10;
  localparam int IMM_SEL_W = 3;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate-format select encodings
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_I = 3'd0;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_S = 3'd1;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_B = 3'd2;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_U = 3'd3;
  localparam logic [IMM_SEL_W-1:0] IMM_SEL_J = 3'd4;

  // Bundle bit positions (match the struct below)
  localparam int BIT_RS2_IMM_SEL = 9;
  localparam int BIT_REG_W_EN    = 8;
  localparam int BIT_MEM_W_EN    = 7;
  localparam int BIT_MEM_R_EN    = 6;
  localparam int BIT_MEM_ALU_SEL = 5;
  localparam int BIT_BRANCH      = 4;
  localparam int BIT_JUMP        = 3;
  localparam int BIT_IMM_SEL_LSB = 0;

  typedef struct packed {
    logic                 rs2_imm_sel;
    logic                 reg_w_en;
    logic                 mem_w_en;
    logic                 mem_r_en;
    logic                 mem_alu_sel;
    logic                 branch;
    logic                 jump;
    logic [IMM_SEL_W-1:0] imm_sel;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: pure combinational RV32I opcode decode.
// Ports:
//   opcode   in  7         instr[6:0]
//   rd       in  REG_AW    destination index (rd=0 suppresses reg_w_en)
//   ctrl     out ctrl_t    control bundle
//   illegal  out 1         opcode not in the supported RV32I set
//   uses_rs1 out 1         instruction reads rs1
//   uses_rs2 out 1         instruction reads rs2
module ctrl_decoder #(
  parameter int REG_AW    = 5,
  parameter int IMM_SEL_W = ctrl_pkg::IMM_SEL_W
) (
  input  logic [6:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  output ctrl_pkg::ctrl_t   ctrl,
  output logic              illegal,
  output logic              uses_rs1,
  output logic              uses_rs2
);
  import ctrl_pkg::*;

  logic [IMM_SEL_W-1:0] imm;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl     = '0;
    imm      = '0;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_w_en    = 1'b1;
        ctrl.mem_alu_sel = 1'b1;
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
      end
      OP_I: begin
        ctrl.rs2_imm_sel = 1'b1;
        ctrl.reg_w_en    = 1'b1;
        ctrl.mem_alu_sel = 1'b1;
        imm              = IMM_SEL_I;
        uses_rs1         = 1'b1;
      end
      OP_LOAD: begin
        ctrl.rs2_imm_sel = 1'b1;
        ctrl.reg_w_en    = 1'b1;
        ctrl.mem_r_en    = 1'b1;
        imm              = IMM_SEL_I;
        uses_rs1         = 1'b1;
      end
      OP_STORE: begin
        ctrl.rs2_imm_sel = 1'b1;
        ctrl.mem_w_en    = 1'b1;
        imm              = IMM_SEL_S;
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        imm         = IMM_SEL_B;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.reg_w_en = 1'b1;
        imm           = IMM_SEL_J;
      end
      OP_JALR: begin
        ctrl.jump        = 1'b1;
        ctrl.reg_w_en    = 1'b1;
        ctrl.rs2_imm_sel = 1'b1;
        imm              = IMM_SEL_I;
        uses_rs1         = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.rs2_imm_sel = 1'b1;
        ctrl.reg_w_en    = 1'b1;
        ctrl.mem_alu_sel = 1'b1;
        imm              = IMM_SEL_U;
      end
      default: illegal = 1'b1;
    endcase
    ctrl.imm_sel = imm;
    // x0 is hardwired: never request a register write to it.
    if (rd == '0) ctrl.reg_w_en = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: main pipeline controller. Decodes the ID instruction and
// carries {valid, rd, illegal, bundle} through EX/MEM/WB stage registers,
// detecting load-use hazards and honouring external stall and branch flush.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid, id_opcode        ID instruction present / instr[6:0]
//   id_rs1, id_rs2, id_rd      ID register indices
//   stall_ext                  freeze EX/MEM/WB
//   flush                      kill the ID instruction (taken branch in EX)
//   hazard_stall               hold PC and IF/ID this cycle (combinational)
//   ex_ctrl/ex_valid/ex_rd     EX-stage slot
//   mem_ctrl/mem_valid/mem_rd  MEM-stage slot
//   wb_ctrl/wb_valid/wb_rd/wb_illegal  WB-stage slot
module pipe_ctrl_unit #(
  parameter int REG_AW    = 5,
  parameter int IMM_SEL_W = ctrl_pkg::IMM_SEL_W,
  parameter int CTRL_W    = ctrl_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              stall_ext,
  input  logic              flush,
  output logic              hazard_stall,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic              mem_valid,
  output logic [REG_AW-1:0] mem_rd,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_illegal
);
  import ctrl_pkg::*;

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  dec_uses_rs1;
  logic  dec_uses_rs2;

  ctrl_decoder #(
    .REG_AW    (REG_AW),
    .IMM_SEL_W (IMM_SEL_W)
  ) u_decoder (
    .opcode   (id_opcode),
    .rd       (id_rd),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2)
  );

  // Stage registers
  logic              ex_valid_q,  mem_valid_q,  wb_valid_q;
  logic [REG_AW-1:0] ex_rd_q,     mem_rd_q,     wb_rd_q;
  logic              ex_ill_q,    mem_ill_q,    wb_ill_q;
  ctrl_t             ex_ctrl_q,   mem_ctrl_q,   wb_ctrl_q;

  // Load-use: the load in EX delivers its data too late for the ID consumer.
  logic hazard_raw;
  assign hazard_raw = id_valid & ex_valid_q & ex_ctrl_q.mem_r_en & (ex_rd_q != '0) &
                      (((ex_rd_q == id_rs1) & dec_uses_rs1) |
                       ((ex_rd_q == id_rs2) & dec_uses_rs2));

  // A flush already kills the ID instruction, so no stall is needed then;
  // under stall_ext the flush is ignored and the raw hazard is reported.
  assign hazard_stall = hazard_raw & (stall_ext | ~flush);

  logic advance;
  logic insert_bubble;
  assign advance       = ~stall_ext;
  assign insert_bubble = flush | hazard_raw | ~id_valid;

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_ill_q    <= 1'b0;
      ex_ctrl_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_ill_q   <= 1'b0;
      mem_ctrl_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_ill_q    <= 1'b0;
      wb_ctrl_q   <= '0;
    end else if (advance) begin
      wb_valid_q  <= mem_valid_q;
      wb_rd_q     <= mem_rd_q;
      wb_ill_q    <= mem_ill_q;
      wb_ctrl_q   <= mem_ctrl_q;
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      mem_ill_q   <= ex_ill_q;
      mem_ctrl_q  <= ex_ctrl_q;
      if (insert_bubble) begin
        ex_valid_q <= 1'b0;
        ex_rd_q    <= '0;
        ex_ill_q   <= 1'b0;
        ex_ctrl_q  <= '0;
      end else begin
        ex_valid_q <= 1'b1;
        ex_rd_q    <= id_rd;
        ex_ill_q   <= dec_illegal;
        ex_ctrl_q  <= dec_ctrl;
      end
    end
  end

  assign ex_ctrl    = ex_ctrl_q;
  assign ex_valid   = ex_valid_q;
  assign ex_rd      = ex_rd_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign mem_valid  = mem_valid_q;
  assign mem_rd     = mem_rd_q;
  assign wb_ctrl    = wb_ctrl_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_illegal = wb_ill_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_ext, flush;
  logic       hazard_stall;
  logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic       ex_valid, mem_valid, wb_valid, wb_illegal;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .stall_ext(stall_ext), .flush(flush), .hazard_stall(hazard_stall),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .mem_ctrl(mem_ctrl), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .wb_ctrl(wb_ctrl), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_illegal(wb_illegal)
  );

  always #5 clk = ~clk;

  // Opcodes and bundle flags as written in the instruction-set table
  localparam bit [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                       BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                       LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b1111111;
  localparam bit [9:0] F_RS2I = 10'h200, F_REGW = 10'h100, F_MEMW = 10'h080, F_MEMR = 10'h040,
                       F_ALU = 10'h020, F_BR = 10'h010, F_J = 10'h008;
  localparam bit [9:0] K_I = 10'd0, K_S = 10'd1, K_B = 10'd2, K_U = 10'd3, K_J = 10'd4;
  localparam bit [9:0] LW_BUNDLE = F_RS2I | F_REGW | F_MEMR | K_I;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       ill;
    logic [9:0] ctrl;
  } mslot_t;

  mslot_t m_ex, m_mem, m_wb;
  int n_cmp = 0;
  int n_fail = 0;

  wire [48:0] dut_vec = {ex_valid, ex_rd, ex_ctrl, mem_valid, mem_rd, mem_ctrl,
                         wb_valid, wb_rd, wb_illegal, wb_ctrl};

  function automatic [48:0] model_vec();
    return {m_ex.valid, m_ex.rd, m_ex.ctrl, m_mem.valid, m_mem.rd, m_mem.ctrl,
            m_wb.valid, m_wb.rd, m_wb.ill, m_wb.ctrl};
  endfunction

  function automatic mslot_t m_decode(logic v, logic [6:0] op, logic [4:0] rd);
    mslot_t s = '0;
    if (!v) return s;
    s.valid = 1'b1;
    s.rd    = rd;
    case (op)
      R:           s.ctrl = F_REGW | F_ALU;
      I:           s.ctrl = F_RS2I | F_REGW | F_ALU | K_I;
      LD:          s.ctrl = F_RS2I | F_REGW | F_MEMR | K_I;
      ST:          s.ctrl = F_RS2I | F_MEMW | K_S;
      BR:          s.ctrl = F_BR | K_B;
      JAL:         s.ctrl = F_J | F_REGW | K_J;
      JALR:        s.ctrl = F_J | F_REGW | F_RS2I | K_I;
      LUI, AUIPC:  s.ctrl = F_RS2I | F_REGW | F_ALU | K_U;
      default:     s.ill  = 1'b1;
    endcase
    if (rd == 5'd0) s.ctrl = s.ctrl & ~F_REGW;
    return s;
  endfunction

  function automatic bit m_hazard();
    bit u1 = (id_opcode inside {R, I, LD, ST, BR, JALR});
    bit u2 = (id_opcode inside {R, ST, BR});
    bit raw = id_valid && m_ex.valid && (m_ex.ctrl & F_MEMR) != 0 && m_ex.rd != 0 &&
              ((m_ex.rd == id_rs1 && u1) || (m_ex.rd == id_rs2 && u2));
    return raw && (stall_ext || !flush);
  endfunction

  // One clock: model computes the next stage contents from the inputs present now.
  task automatic tick();
    bit kill;
    mslot_t n_ex = m_ex, n_mem = m_mem, n_wb = m_wb;
    if (!stall_ext) begin
      kill  = flush || m_hazard();
      n_wb  = m_mem;
      n_mem = m_ex;
      n_ex  = kill ? mslot_t'('0) : m_decode(id_valid, id_opcode, id_rd);
    end
    @(posedge clk);
    m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
    #1;
  endtask

  task automatic set_id(logic v, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
  endtask

  task automatic test_reset();
    set_id(1, R, 1, 2, 3); tick();
    set_id(1, I, 1, 0, 4); tick();
    set_id(1, LD, 1, 0, 5); tick();
    set_id(1, R, 5, 1, 6);
    #1;
    n_cmp++;
    if (!(ex_valid && mem_valid && wb_valid) || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reset_prefill: got %h want %h", dut_vec, model_vec());
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 49'd0) begin
      n_fail++; $display("FAIL reset_async_outputs: got %h want 0", dut_vec);
    end
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_hazard: got %b want 0", hazard_stall);
    end
    m_ex = '0; m_mem = '0; m_wb = '0;
    set_id(0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec !== 49'd0) begin
      n_fail++; $display("FAIL reset_release: got %h want 0", dut_vec);
    end
  endtask

  task automatic test_stream();
    bit [6:0] ops [7] = '{R, I, ST, LD, BR, JAL, LUI};
    bit [4:0] rds [7] = '{3, 4, 0, 7, 0, 8, 9};
    bit [9:0] tbl [7] = '{10'b0100100000, 10'b1100100000, 10'b1010000001, 10'b1101000000,
                          10'b0000010010, 10'b0100001100, 10'b1100100011};
    for (int i = 0; i < 9; i++) begin
      if (i < 7) set_id(1, ops[i], 5'd1, 5'd2, rds[i]);
      else       set_id(0, 0, 0, 0, 0);
      tick();
      if (i < 7) begin
        n_cmp++;
        if (ex_ctrl !== tbl[i] || ex_rd !== rds[i] || ex_valid !== 1'b1) begin
          n_fail++; $display("FAIL stream_ex[%0d]: got %b rd %0d want %b rd %0d", i, ex_ctrl, ex_rd, tbl[i], rds[i]);
        end
      end
      if (i >= 2) begin
        n_cmp++;
        if (wb_ctrl !== tbl[i-2] || wb_rd !== rds[i-2] || wb_valid !== 1'b1) begin
          n_fail++; $display("FAIL stream_wb[%0d]: got %b want %b", i-2, wb_ctrl, tbl[i-2]);
        end
      end
    end
  endtask

  task automatic test_hazard();
    set_id(1, LD, 1, 0, 5); tick();
    set_id(1, R, 5, 1, 6); #1;
    n_cmp++;
    if (hazard_stall !== 1'b1) begin
      n_fail++; $display("FAIL hazard_lw_use: got %b want 1", hazard_stall);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0 || hazard_stall !== 1'b0 || mem_ctrl !== LW_BUNDLE) begin
      n_fail++; $display("FAIL hazard_bubble: ex_valid %b stall %b mem %b want 0 0 %b", ex_valid, hazard_stall, mem_ctrl, LW_BUNDLE);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
      n_fail++; $display("FAIL hazard_add_reaches_ex: got valid %b rd %0d want 1 6", ex_valid, ex_rd);
    end
    set_id(1, LUI, 0, 0, 5); tick();
    set_id(1, R, 1, 5, 6); #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL hazard_after_lui: got %b want 0", hazard_stall);
    end
    tick();
    set_id(1, LD, 1, 0, 0); tick();
    set_id(1, R, 0, 0, 6); #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL hazard_x0: got %b want 0", hazard_stall);
    end
    tick();
    set_id(1, LD, 1, 0, 5); tick();
    set_id(1, LUI, 5, 5, 5); #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL hazard_lui_no_src: got %b want 0", hazard_stall);
    end
    tick();
    n_cmp++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL hazard_model: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_flush();
    set_id(1, LD, 1, 0, 5); tick();
    set_id(1, R, 5, 1, 6); flush = 1'b1; #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_hazard_masked: got %b want 0", hazard_stall);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0 || mem_valid !== 1'b1 || mem_rd !== 5'd5 || mem_ctrl !== LW_BUNDLE) begin
      n_fail++; $display("FAIL flush_advance: ex_valid %b mem_rd %0d mem %b want 0 5 %b", ex_valid, mem_rd, mem_ctrl, LW_BUNDLE);
    end
    flush = 1'b0;
  endtask

  task automatic test_stall_ext();
    logic [48:0] snap;
    set_id(1, I, 1, 0, 4); tick();
    set_id(1, LD, 1, 0, 5); tick();
    set_id(1, R, 5, 1, 6); stall_ext = 1'b1; flush = 1'b1;
    snap = model_vec();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (hazard_stall !== 1'b1) begin
        n_fail++; $display("FAIL stall_ext_hazard[%0d]: got %b want 1", c, hazard_stall);
      end
      tick();
      n_cmp++;
      if (dut_vec !== snap) begin
        n_fail++; $display("FAIL stall_ext_frozen[%0d]: got %h want %h", c, dut_vec, snap);
      end
    end
    stall_ext = 1'b0; #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_release_hazard: got %b want 0", hazard_stall);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0 || mem_rd !== 5'd5 || mem_ctrl !== LW_BUNDLE || wb_rd !== 5'd4) begin
      n_fail++; $display("FAIL stall_release_flush: ex_valid %b mem_rd %0d wb_rd %0d want 0 5 4", ex_valid, mem_rd, wb_rd);
    end
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0);
  endtask

  task automatic test_illegal();
    bit [0:0] want [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    set_id(1, BAD, 1, 2, 9); tick();
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_ctrl !== 10'd0) begin
      n_fail++; $display("FAIL illegal_ex: valid %b ctrl %b want 1 0", ex_valid, ex_ctrl);
    end
    n_cmp++;
    if (wb_illegal !== want[0]) begin
      n_fail++; $display("FAIL illegal_wb[0]: got %b want %b", wb_illegal, want[0]);
    end
    set_id(0, R, 1, 2, 3);
    for (int c = 1; c < 4; c++) begin
      tick();
      if (c == 1) begin
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 10'd0 || ex_rd !== 5'd0) begin
          n_fail++; $display("FAIL idle_bubble: valid %b ctrl %b rd %0d want 0 0 0", ex_valid, ex_ctrl, ex_rd);
        end
      end
      n_cmp++;
      if (wb_illegal !== want[c]) begin
        n_fail++; $display("FAIL illegal_wb[%0d]: got %b want %b", c, wb_illegal, want[c]);
      end
    end
  endtask

  task automatic test_random();
    bit [6:0] ops [11] = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC, BAD, 7'b0001111};
    for (int c = 0; c < 400; c++) begin
      set_id($urandom_range(9, 0) < 8, ops[$urandom_range(10, 0)],
             5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)));
      stall_ext = ($urandom_range(9, 0) == 0);
      flush     = ($urandom_range(9, 0) == 0);
      #1;
      n_cmp++;
      if (hazard_stall !== m_hazard()) begin
        n_fail++; $display("FAIL rand_hazard[%0d]: got %b want %b", c, hazard_stall, m_hazard());
      end
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL rand_state[%0d]: got %h want %h", c, dut_vec, model_vec());
      end
    end
    stall_ext = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; stall_ext = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0);
    m_ex = '0; m_mem = '0; m_wb = '0;
    #2;
    n_cmp++;
    if (dut_vec !== 49'd0 || hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL initial_reset: got %h stall %b want 0", dut_vec, hazard_stall);
    end
    #10 rst_n = 1'b1;
    tick();
    test_reset();
    test_stream();
    test_hazard();
    test_flush();
    test_stall_ext();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
